// File: rtl/rtsnoc_rmi_initiator.sv
// RTSNoC RMI initiator: splits one request message into NoC flits, then
// collects and reassembles the reply flits, with a reply timeout.
module rtsnoc_rmi_initiator #(
  parameter int SIZE_X         = 1,
  parameter int SIZE_Y         = 1,
  parameter int SIZE_DATA      = 56,
  parameter int RMI_MSG_SIZE   = 80,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int BUS_SIZE      = SIZE_DATA + 2*SIZE_X + 2*SIZE_Y + 6
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic [BUS_SIZE-1:0]     din_o,
  output logic                    wr_o,
  output logic                    rd_o,
  input  logic [BUS_SIZE-1:0]     dout_i,
  input  logic                    wait_i,
  input  logic                    nd_i,
  input  logic [SIZE_X-1:0]       x,
  input  logic [SIZE_Y-1:0]       y,
  input  logic [2:0]              local_addr,
  input  logic [RMI_MSG_SIZE-1:0] req_msg_i,
  input  logic [SIZE_X-1:0]       req_dst_x_i,
  input  logic [SIZE_Y-1:0]       req_dst_y_i,
  input  logic [2:0]              req_dst_h_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  output logic [RMI_MSG_SIZE-1:0] resp_msg_o,
  output logic                    resp_err_o,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic                    busy_o,
  output logic [7:0]              drop_cnt_o
);

  localparam int NFLITS = (RMI_MSG_SIZE + SIZE_DATA - 1) / SIZE_DATA;
  localparam int IDXW   = (NFLITS > 1) ? $clog2(NFLITS) : 1;
  localparam int TW     = $clog2(TIMEOUT_CYCLES);
  localparam int HDR    = 2*(SIZE_X + SIZE_Y + 3);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NFLITS - 1);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TX, WAIT_RESP, RESP} state_t;

  state_t                    state_reg, state_next;
  logic [RMI_MSG_SIZE-1:0]   tx_msg_reg;
  logic [SIZE_X-1:0]         dst_x_reg;
  logic [SIZE_Y-1:0]         dst_y_reg;
  logic [2:0]                dst_h_reg;
  logic [IDXW-1:0]           idx_reg;
  logic [TW-1:0]             tmo_reg;
  logic [RMI_MSG_SIZE-1:0]   rx_buf_reg, rx_next;
  logic                      resp_err_reg;
  logic                      req_ready_reg;
  logic [7:0]                drop_cnt_reg;

  logic [NFLITS*SIZE_DATA-1:0] tx_pad;
  logic [SIZE_DATA-1:0]        tx_slice;
  logic                        hdr_match, rx_accept, last_rx, timeout;

  always_comb begin
    tx_pad = '0;
    tx_pad[RMI_MSG_SIZE-1:0] = tx_msg_reg;
  end
  assign tx_slice = tx_pad[idx_reg*SIZE_DATA +: SIZE_DATA];

  // A reply must come from the node we addressed and be addressed to us.
  assign hdr_match = (dout_i[BUS_SIZE-1 -: HDR] ==
                      {dst_x_reg, dst_y_reg, dst_h_reg, x, y, local_addr});
  assign rd_o      = nd_i && ((state_reg == WAIT_RESP) || (state_reg == RESP));
  assign rx_accept = nd_i && (state_reg == WAIT_RESP) && hdr_match;
  assign last_rx   = rx_accept && (idx_reg == LAST_IDX);
  assign timeout   = (state_reg == WAIT_RESP) && (tmo_reg == TO_LAST) && !last_rx;

  assign wr_o         = (state_reg == TX);
  assign din_o        = wr_o ? {x, y, local_addr, dst_x_reg, dst_y_reg, dst_h_reg, tx_slice} : '0;
  assign req_ready_o  = req_ready_reg;
  assign resp_valid_o = (state_reg == RESP);
  assign resp_err_o   = resp_err_reg;
  assign resp_msg_o   = rx_buf_reg;
  assign busy_o       = (state_reg != IDLE);
  assign drop_cnt_o   = drop_cnt_reg;

  // Reply slices land in place; padding bits of the last slice fall away.
  genvar gi;
  for (gi = 0; gi < NFLITS; gi++) begin : g_rx
    localparam int LO = gi * SIZE_DATA;
    localparam int W  = (RMI_MSG_SIZE - LO < SIZE_DATA) ? (RMI_MSG_SIZE - LO) : SIZE_DATA;
    assign rx_next[LO +: W] = (rx_accept && (idx_reg == IDXW'(gi))) ? dout_i[W-1:0]
                                                                    : rx_buf_reg[LO +: W];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (req_valid_i && req_ready_reg)       state_next = TX;
      TX:        if (!wait_i && (idx_reg == LAST_IDX))   state_next = WAIT_RESP;
      WAIT_RESP: if (last_rx || timeout)                 state_next = RESP;
      RESP:      if (resp_ready_i)                       state_next = IDLE;
      default:                                           state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg     <= IDLE;
      tx_msg_reg    <= '0;
      dst_x_reg     <= '0;
      dst_y_reg     <= '0;
      dst_h_reg     <= '0;
      idx_reg       <= '0;
      tmo_reg       <= '0;
      rx_buf_reg    <= '0;
      resp_err_reg  <= 1'b0;
      req_ready_reg <= 1'b0;
      drop_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      req_ready_reg <= (state_next == IDLE);
      case (state_reg)
        IDLE: begin
          if (req_valid_i && req_ready_reg) begin
            tx_msg_reg   <= req_msg_i;
            dst_x_reg    <= req_dst_x_i;
            dst_y_reg    <= req_dst_y_i;
            dst_h_reg    <= req_dst_h_i;
            idx_reg      <= '0;
            tmo_reg      <= '0;
            rx_buf_reg   <= '0;
            resp_err_reg <= 1'b0;
          end
        end
        TX: begin
          if (!wait_i) begin
            idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + IDXW'(1);
            tmo_reg <= '0;
          end
        end
        WAIT_RESP: begin
          tmo_reg <= tmo_reg + TW'(1);
          if (rx_accept) begin
            rx_buf_reg <= rx_next;
            idx_reg    <= (idx_reg == LAST_IDX) ? '0 : idx_reg + IDXW'(1);
          end
          if (timeout) begin
            rx_buf_reg   <= '0;
            resp_err_reg <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready_i) resp_err_reg <= 1'b0;
        end
        default: ;
      endcase
      if (rd_o && !rx_accept && (drop_cnt_reg != 8'hFF))
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

endmodule

// File: tb/tb_rtsnoc_rmi_initiator.sv
// Directed + randomized bench for rtsnoc_rmi_initiator against a message-level model.
module tb_rtsnoc_rmi_initiator;

  localparam int SD  = 56;
  localparam int RMI = 80;
  localparam int TMO = 16;
  localparam int BUS = 66;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [BUS-1:0]  din_o, dout_i;
  logic            wr_o, rd_o, wait_i, nd_i;
  logic [0:0]      x, y;
  logic [2:0]      local_addr;
  logic [RMI-1:0]  req_msg_i, resp_msg_o;
  logic [0:0]      req_dst_x_i, req_dst_y_i;
  logic [2:0]      req_dst_h_i;
  logic            req_valid_i, req_ready_o, resp_err_o, resp_valid_o, resp_ready_i, busy_o;
  logic [7:0]      drop_cnt_o;

  always #5 clk = ~clk;

  rtsnoc_rmi_initiator #(
    .SIZE_X(1), .SIZE_Y(1), .SIZE_DATA(SD), .RMI_MSG_SIZE(RMI), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .din_o(din_o), .wr_o(wr_o), .rd_o(rd_o),
    .dout_i(dout_i), .wait_i(wait_i), .nd_i(nd_i), .x(x), .y(y), .local_addr(local_addr),
    .req_msg_i(req_msg_i), .req_dst_x_i(req_dst_x_i), .req_dst_y_i(req_dst_y_i),
    .req_dst_h_i(req_dst_h_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .resp_msg_o(resp_msg_o), .resp_err_o(resp_err_o), .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i), .busy_o(busy_o), .drop_cnt_o(drop_cnt_o)
  );

  int vectors = 0;
  int miscompares = 0;
  int accepts = 0;
  int drop_model = 0;
  logic [4:0] own_hdr;

  always @(posedge clk) if (wr_o && !wait_i) accepts <= accepts + 1;

  task automatic chk(input string nm, input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s observed=%0h expected=%0h", nm, tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outbound flit k: own header, target header, k-th 56-bit chunk of the zero-padded message.
  function automatic logic [BUS-1:0] exp_flit(input logic [RMI-1:0] m, input logic [4:0] dst, input int k);
    logic [2*SD-1:0] p;
    p = {32'b0, m};
    return {own_hdr, dst, p[k*SD +: SD]};
  endfunction

  function automatic logic [2*SD-1:0] rnd112();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_flit(input string nm, input logic [BUS-1:0] f);
    nd_i   = 1'b1;
    dout_i = f;
    #1;
    chk(nm, "rd_o_on_nd", rd_o, 1'b1);
    tick();
    nd_i   = 1'b0;
    dout_i = rnd112();
  endtask

  task automatic do_txn(input string nm, input logic [RMI-1:0] msg, input logic [4:0] dst,
                        input int w0, input int w1, input bit foreign, input int gap,
                        input bit noreply, input int hold, input bit flood);
    int n, a0, nw;
    logic [2*SD-1:0] rep;
    logic [RMI-1:0]  exp_resp;
    n = 0;
    while (!req_ready_o && n < 50) begin tick(); n++; end
    chk(nm, "req_ready_idle", req_ready_o, 1'b1);
    req_msg_i = msg;
    {req_dst_x_i, req_dst_y_i, req_dst_h_i} = dst;
    req_valid_i = 1'b1;
    a0 = accepts;
    tick();
    req_valid_i = 1'b0;
    req_msg_i = rnd112();
    {req_dst_x_i, req_dst_y_i, req_dst_h_i} = 5'($urandom);
    chk(nm, "req_ready_tx", req_ready_o, 1'b0);
    chk(nm, "busy_tx", busy_o, 1'b1);
    for (int k = 0; k < 2; k++) begin
      nw = (k == 0) ? w0 : w1;
      for (int w = 0; w < nw; w++) begin
        wait_i = 1'b1;
        #1;
        chk(nm, "wr_hold", wr_o, 1'b1);
        chk(nm, "din_hold", din_o, exp_flit(msg, dst, k));
        tick();
      end
      wait_i = 1'b0;
      #1;
      chk(nm, "wr_acc", wr_o, 1'b1);
      chk(nm, "din_acc", din_o, exp_flit(msg, dst, k));
      tick();
    end
    chk(nm, "wr_drop", wr_o, 1'b0);
    chk(nm, "accept_count", accepts - a0, 2);
    rep = rnd112();
    exp_resp = rep[RMI-1:0];
    if (noreply) begin
      n = 0;
      while (!resp_valid_o && n < 100) begin
        #1;
        if (rd_o) chk(nm, "rd_without_nd", rd_o, 1'b0);
        tick();
        n++;
      end
      chk(nm, "timeout_cycles", n, TMO);
      chk(nm, "timeout_err", resp_err_o, 1'b1);
      chk(nm, "timeout_msg", resp_msg_o, '0);
      exp_resp = '0;
    end else begin
      send_flit(nm, {dst, own_hdr, rep[SD-1:0]});
      if (foreign) begin
        send_flit(nm, {1'b0, 1'b1, 3'd3, own_hdr, 56'(rnd112())});
        drop_model = (drop_model < 255) ? drop_model + 1 : 255;
      end
      for (int g = 0; g < gap; g++) begin
        #1;
        chk(nm, "rd_idle", rd_o, 1'b0);
        chk(nm, "no_early_resp", resp_valid_o, 1'b0);
        tick();
      end
      send_flit(nm, {dst, own_hdr, rep[2*SD-1:SD]});
      chk(nm, "resp_valid", resp_valid_o, 1'b1);
      chk(nm, "resp_err", resp_err_o, 1'b0);
      chk(nm, "resp_msg", resp_msg_o, exp_resp);
    end
    resp_ready_i = 1'b0;
    for (int h = 0; h < hold; h++) begin
      nd_i = flood;
      dout_i = {dst, own_hdr, 56'(rnd112())};
      #1;
      chk(nm, "hold_rd", rd_o, flood);
      chk(nm, "hold_valid", resp_valid_o, 1'b1);
      chk(nm, "hold_msg", resp_msg_o, exp_resp);
      chk(nm, "hold_err", resp_err_o, noreply);
      chk(nm, "hold_req_ready", req_ready_o, 1'b0);
      tick();
      if (flood) drop_model = (drop_model < 255) ? drop_model + 1 : 255;
    end
    nd_i = 1'b0;
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    chk(nm, "post_valid", resp_valid_o, 1'b0);
    chk(nm, "post_err", resp_err_o, 1'b0);
    chk(nm, "post_req_ready", req_ready_o, 1'b1);
    chk(nm, "post_busy", busy_o, 1'b0);
    chk(nm, "drop_cnt", drop_cnt_o, drop_model[7:0]);
    $display("txn %s dst=%h msg=%h exp_resp=%h err=%0d drop=%0d", nm, dst, msg, exp_resp, noreply, drop_cnt_o);
  endtask

  initial begin
    x = 1'b0; y = 1'b0; local_addr = 3'd1;
    own_hdr = {x, y, local_addr};
    wait_i = 1'b0; nd_i = 1'b0; dout_i = '0;
    req_msg_i = '0; req_dst_x_i = '0; req_dst_y_i = '0; req_dst_h_i = '0;
    req_valid_i = 1'b0; resp_ready_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset", "wr", wr_o, 1'b0);
    chk("reset", "din", din_o, '0);
    chk("reset", "req_ready", req_ready_o, 1'b0);
    chk("reset", "resp_valid", resp_valid_o, 1'b0);
    chk("reset", "resp_msg", resp_msg_o, '0);
    chk("reset", "busy", busy_o, 1'b0);
    chk("reset", "drop", drop_cnt_o, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_txn("basic",    80'h0123_4567_89AB_CDEF_1357, 5'b11010, 0, 0, 0, 0, 0, 1, 0);
    do_txn("backpres", rnd112(), 5'b11010, 5, 3, 0, 0, 0, 1, 0);
    do_txn("foreign",  rnd112(), 5'b11010, 0, 0, 1, 0, 0, 1, 0);
    do_txn("timeout",  rnd112(), 5'b10110, 0, 0, 0, 0, 1, 2, 0);
    do_txn("coincide", rnd112(), 5'b01101, 0, 0, 0, 14, 0, 1, 0);
    do_txn("hold",     rnd112(), 5'b11010, 1, 0, 0, 0, 0, 10, 0);
    for (int r = 0; r < 6; r++)
      do_txn("random", rnd112(), 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             0, $urandom_range(0, 4), 0, $urandom_range(1, 4), 1'($urandom));
    do_txn("saturate", rnd112(), 5'b00111, 0, 0, 0, 0, 0, 260, 1);

    // Abort mid-TX while the router holds off the first flit.
    req_msg_i = rnd112();
    {req_dst_x_i, req_dst_y_i, req_dst_h_i} = 5'b11010;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    wait_i = 1'b1;
    #1;
    chk("rst_mid", "wr_before", wr_o, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", "wr", wr_o, 1'b0);
    chk("rst_mid", "rd", rd_o, 1'b0);
    chk("rst_mid", "din", din_o, '0);
    chk("rst_mid", "req_ready", req_ready_o, 1'b0);
    chk("rst_mid", "busy", busy_o, 1'b0);
    chk("rst_mid", "resp_valid", resp_valid_o, 1'b0);
    chk("rst_mid", "drop", drop_cnt_o, 8'd0);
    drop_model = 0;
    wait_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn rst_mid aborted wr=%0d busy=%0d", wr_o, busy_o);
    do_txn("post_rst", rnd112(), 5'b11010, 1, 1, 0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rtsnoc_rmi_initiator.md
Name: rtsnoc_rmi_initiator

Overview:
- Initiator end of the RTSNoC RMI channel. Hardware components are wrapped as responders by the existing channel bridge; this block issues the requests to them.
- Accepts one RMI_MSG_SIZE-bit request from a local master and splits it into NoC flits addressed to a target node. It then waits for the reply flits, reassembles them and returns the response.
- One transaction is outstanding at a time. A reply timeout produces an error response.

Parameters:
SIZE_X, 1, log2 of mesh X dimension
SIZE_Y, 1, log2 of mesh Y dimension
SIZE_DATA, 56, payload bits per flit
RMI_MSG_SIZE, 80, RMI message width
TIMEOUT_CYCLES, 1024, cycles allowed in WAIT_RESP before error (>=2)
Derived: BUS_SIZE = SIZE_DATA+2*SIZE_X+2*SIZE_Y+6; NFLITS = ceil(RMI_MSG_SIZE/SIZE_DATA) (2 at defaults)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-low reset
din_o  out  BUS_SIZE  flit to router; fields MSB->LSB: src_x, src_y, src_h[2:0], dst_x, dst_y, dst_h[2:0], data
wr_o  out  1  flit write request
rd_o  out  1  flit read strobe
dout_i  in  BUS_SIZE  flit from router, same field layout
wait_i  in  1  router busy; write not accepted
nd_i  in  1  new flit present on dout_i
x  in  SIZE_X  own X coordinate
y  in  SIZE_Y  own Y coordinate
local_addr  in  3  own router local port
req_msg_i  in  RMI_MSG_SIZE  request message
req_dst_x_i  in  SIZE_X  target X
req_dst_y_i  in  SIZE_Y  target Y
req_dst_h_i  in  3  target local port
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
resp_msg_o  out  RMI_MSG_SIZE  reassembled reply
resp_err_o  out  1  reply timed out; resp_msg_o is all zeros
resp_valid_o  out  1  response valid, held until resp_ready_i
resp_ready_i  in  1  local master consumes response
busy_o  out  1  state != IDLE
drop_cnt_o  out  8  count of discarded foreign flits, saturating

Behaviour:
- Reset (rst_i=0, async): state IDLE. Outputs: wr_o=0, rd_o=0, din_o=0, req_ready_o=0, resp_valid_o=0, resp_err_o=0, resp_msg_o=0, busy_o=0, drop_cnt_o=0. Flit index, timeout counter and message buffer clear.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: capture message and destination, then go to TX with flit idx=0.
  - req_ready_o is 0 in every other state.
- TX:
  - wr_o=1. din_o = {x,y,local_addr,dst_x,dst_y,dst_h, slice idx}. Slice idx = message bits [idx*SIZE_DATA +: SIZE_DATA]; the last slice is zero-padded.
  - A flit is accepted on any cycle with wr_o=1 and wait_i=0.
  - While wait_i=1, din_o and wr_o are held unchanged.
  - On accept: idx++. After flit NFLITS-1 is accepted, go to WAIT_RESP with idx=0 and timeout counter=0. wr_o drops that same cycle.
- WAIT_RESP/RX:
  - When nd_i=1, rd_o=1 for one cycle and dout_i is sampled in that cycle. rd_o is never asserted while nd_i=0.
  - Flit is accepted if src fields == captured dst and dst fields == {x,y,local_addr}. The accepted flit's data goes into reply slice idx, then idx++.
  - Any other flit is discarded and drop_cnt_o increments, saturating at 255.
  - After NFLITS accepted flits, go to RESP.
  - Timeout counter increments every cycle in WAIT_RESP/RX. It is not reset by accepted flits.
  - When the counter reaches TIMEOUT_CYCLES-1 and the last flit is not accepted that cycle: go to RESP with resp_err_o=1 and resp_msg_o=0.
  - If the last flit and the timeout coincide, the flit wins (resp_err_o=0).
- RESP:
  - resp_valid_o=1; resp_msg_o and resp_err_o are held stable.
  - On resp_ready_i, go to IDLE. resp_valid_o and resp_err_o clear the next cycle.
  - While in RESP, arriving nd_i flits are read and discarded (drop_cnt_o++). This keeps the router port from blocking.
- Latency:
  - Request accepted at cycle t: first wr_o at t+1.
  - Minimum request-to-resp_valid_o time = NFLITS write cycles + NFLITS read cycles + 1.
- Reset asserted mid-transaction: abort immediately with no residual wr_o/rd_o. A partial packet already in the NoC is not recovered.
- Reply slice bits above RMI_MSG_SIZE are discarded.

Test Plan:
- Basic round trip: own (0,0,h=1), dst (1,1,h=2), wait_i=0, msg=80'h0123_4567_89AB_CDEF_1357 -> two flits; flit0 data = 56'h67_89AB_CDEF_1357, flit1 = 56'h0000_0000_0123_45. Echo the two reply flits from (1,1,2) -> resp_msg_o equals the sent msg, resp_err_o=0.
- Backpressure: wait_i=1 for 5 cycles on flit0, then 3 cycles on flit1 -> din_o stable while waiting; exactly 2 accepts; no duplicate flit.
- Foreign flit: during WAIT_RESP inject a flit from (0,1,3) between the two valid reply flits -> it is read and dropped, drop_cnt_o=1, the response is correct.
- Timeout: TIMEOUT_CYCLES=16 with no reply -> resp_valid_o with resp_err_o=1 and resp_msg_o=0 exactly 16 cycles after entering WAIT_RESP.
- Response hold: resp_ready_i=0 for 10 cycles -> resp_valid_o and data stable, req_ready_o=0. Then ready=1 -> IDLE, req_ready_o=1 the next cycle.
- Reset mid-TX: drop rst_i while wr_o=1 -> wr_o=0 asynchronously and all outputs at reset values. A new request after release completes normally.
